// File: rtl/dmem_arbiter_if.sv
// Data-memory sharing bus: CPU MEM-stage port, debug/loader port and the single memory port.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [3:0]        cpu_be;
  logic              cpu_stall;
  logic [31:0]       cpu_rdata;
  logic              cpu_rvalid;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [31:0]       dbg_wdata;
  logic [3:0]        dbg_be;
  logic              dbg_gnt;
  logic [31:0]       dbg_rdata;
  logic              dbg_rvalid;
  logic              dbg_halt_req;
  logic              dbg_halted;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic [31:0]       mem_rdata;

  logic              err;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_be, dbg_halt_req,
    input  mem_rdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    output dbg_gnt, dbg_rdata, dbg_rvalid, dbg_halted,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    output err
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_be, dbg_halt_req,
    output mem_rdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    input  dbg_gnt, dbg_rdata, dbg_rvalid, dbg_halted,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    input  err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the CPU MEM stage and a debug port.
// Grant is combinational; read data returns one cycle later; a halt FSM lets debug own memory.
module dmem_arbiter #(
  parameter int DATA_MEM_SIZE = 1024,
  parameter int ADDR_W        = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  localparam logic [ADDR_W-3:0] MAX_WORD = (ADDR_W-2)'(DATA_MEM_SIZE/4 - 1);

  state_t state_q;
  logic   last_dbg_q;
  logic   pend_q;
  logic   owner_cpu_q;
  logic   oor_q;
  logic   err_q;
  logic   halted_q;

  logic cpu_oor, dbg_oor;
  logic cpu_elig, cpu_gnt, dbg_gnt, any_gnt;
  logic win_oor, win_we;
  logic pend_d, err_d, last_dbg_d;
  logic unused_addr_lsb;

  assign cpu_oor = bus.cpu_addr[ADDR_W-1:2] > MAX_WORD;
  assign dbg_oor = bus.dbg_addr[ADDR_W-1:2] > MAX_WORD;

  // The CPU is also shut out in the cycle halt is requested, so nothing new is in flight in DRAIN.
  assign cpu_elig = rst_n && (state_q == RUN) && !bus.dbg_halt_req;
  assign cpu_gnt  = bus.cpu_req & cpu_elig & (~bus.dbg_req | last_dbg_q);
  assign dbg_gnt  = bus.dbg_req & ~cpu_gnt;
  assign any_gnt  = cpu_gnt | dbg_gnt;

  assign win_oor = cpu_gnt ? cpu_oor : dbg_oor;
  assign win_we  = cpu_gnt ? bus.cpu_we : bus.dbg_we;

  assign pend_d     = any_gnt & ~win_we;
  assign err_d      = err_q | (any_gnt & win_oor);
  assign last_dbg_d = any_gnt ? dbg_gnt : last_dbg_q;

  assign bus.mem_en    = any_gnt & ~win_oor;
  assign bus.mem_we    = bus.mem_en & win_we;
  assign bus.mem_addr  = cpu_gnt ? bus.cpu_addr[ADDR_W-1:2] : bus.dbg_addr[ADDR_W-1:2];
  assign bus.mem_wdata = cpu_gnt ? bus.cpu_wdata : bus.dbg_wdata;
  assign bus.mem_be    = cpu_gnt ? bus.cpu_be : bus.dbg_be;

  assign bus.cpu_stall = bus.cpu_req & ~cpu_gnt;
  assign bus.dbg_gnt   = dbg_gnt;

  // Out-of-range reads never touched memory, so their return is forced to zero.
  assign bus.cpu_rvalid = pend_q & owner_cpu_q;
  assign bus.dbg_rvalid = pend_q & ~owner_cpu_q;
  assign bus.cpu_rdata  = (bus.cpu_rvalid && !oor_q) ? bus.mem_rdata : 32'h0;
  assign bus.dbg_rdata  = (bus.dbg_rvalid && !oor_q) ? bus.mem_rdata : 32'h0;

  assign bus.dbg_halted = halted_q;
  assign bus.err        = err_q;

  assign unused_addr_lsb = ^{bus.cpu_addr[1:0], bus.dbg_addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      halted_q    <= 1'b0;
      last_dbg_q  <= 1'b1;
      pend_q      <= 1'b0;
      owner_cpu_q <= 1'b0;
      oor_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.dbg_halt_req) state_q <= DRAIN;
        end
        DRAIN: begin
          if (bus.dbg_halt_req) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end else begin
            state_q  <= RUN;
          end
        end
        HALTED: begin
          if (!bus.dbg_halt_req) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= RUN;
          halted_q <= 1'b0;
        end
      endcase
      last_dbg_q  <= last_dbg_d;
      pend_q      <= pend_d;
      owner_cpu_q <= cpu_gnt;
      oor_q       <= win_oor;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table for arbitration, routing, halt and range errors,
// plus hand-written sequences for DRAIN abort and reset during an outstanding read.
module tb_dmem_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  dmem_arbiter_if #(.ADDR_W(32)) bus ();

  dmem_arbiter #(.DATA_MEM_SIZE(1024), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous one-cycle-latency memory, 256 words.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) mem[bus.mem_addr[7:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end else begin
        bus.mem_rdata <= mem[bus.mem_addr[7:0]];
      end
    end
  end

  typedef struct {
    logic        creq, cwe;
    logic [31:0] caddr, cwdata;
    logic [3:0]  cbe;
    logic        dreq, dwe;
    logic [31:0] daddr, dwdata;
    logic [3:0]  dbe;
    logic        halt;
    logic        stall, dgnt, en, we;
    logic [29:0] maddr;
    logic [3:0]  mbe;
    logic [31:0] mwd;
    logic        crv;
    logic [31:0] crd;
    logic        drv;
    logic [31:0] drd;
    logic        halted, err;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vt [NVEC];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic creq, input logic cwe, input logic [31:0] caddr,
                       input logic [31:0] cwdata, input logic [3:0] cbe,
                       input logic dreq, input logic dwe, input logic [31:0] daddr,
                       input logic [31:0] dwdata, input logic [3:0] dbe, input logic halt);
    bus.cpu_req = creq;  bus.cpu_we = cwe;  bus.cpu_addr = caddr;
    bus.cpu_wdata = cwdata;  bus.cpu_be = cbe;
    bus.dbg_req = dreq;  bus.dbg_we = dwe;  bus.dbg_addr = daddr;
    bus.dbg_wdata = dwdata;  bus.dbg_be = dbe;
    bus.dbg_halt_req = halt;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    mem[4] <= 32'hDEADBEEF;
    mem[5] <= 32'hCAFEF00D;
    mem[8] <= 32'h11111111;

    //        creq cwe caddr  cwdata       cbe  dreq dwe daddr  dwdata       dbe  halt | stall dgnt en we maddr mbe  mwd           crv crd            drv drd            halted err
    vt[0]  = '{0, 0, 0,      0,           0,   0, 0, 0,      0,           0,   0,   0, 0, 0, 0, 0,     0,   0,            0, 0,            0, 0,            0, 0};
    vt[1]  = '{1, 0, 'h10,   0,           'hF, 1, 0, 'h14,   0,           'hF, 0,   0, 0, 1, 0, 4,     'hF, 0,            0, 0,            0, 0,            0, 0};
    vt[2]  = '{1, 0, 'h10,   0,           'hF, 1, 0, 'h14,   0,           'hF, 0,   1, 1, 1, 0, 5,     'hF, 0,            1, 'hDEADBEEF,   0, 0,            0, 0};
    vt[3]  = '{1, 0, 'h10,   0,           'hF, 1, 0, 'h14,   0,           'hF, 0,   0, 0, 1, 0, 4,     'hF, 0,            0, 0,            1, 'hCAFEF00D,   0, 0};
    vt[4]  = '{1, 0, 'h10,   0,           'hF, 1, 0, 'h14,   0,           'hF, 0,   1, 1, 1, 0, 5,     'hF, 0,            1, 'hDEADBEEF,   0, 0,            0, 0};
    vt[5]  = '{0, 0, 0,      0,           0,   0, 0, 0,      0,           0,   0,   0, 0, 0, 0, 0,     0,   0,            0, 0,            1, 'hCAFEF00D,   0, 0};
    vt[6]  = '{1, 1, 'h20,   'h0000AB00,  'h2, 0, 0, 0,      0,           0,   0,   0, 0, 1, 1, 8,     'h2, 'h0000AB00,   0, 0,            0, 0,            0, 0};
    vt[7]  = '{0, 0, 0,      0,           0,   0, 0, 0,      0,           0,   0,   0, 0, 0, 0, 0,     0,   0,            0, 0,            0, 0,            0, 0};
    vt[8]  = '{1, 0, 'h20,   0,           'hF, 0, 0, 0,      0,           0,   0,   0, 0, 1, 0, 8,     'hF, 0,            0, 0,            0, 0,            0, 0};
    vt[9]  = '{0, 0, 0,      0,           0,   0, 0, 0,      0,           0,   0,   0, 0, 0, 0, 0,     0,   0,            1, 'h1111AB11,   0, 0,            0, 0};
    vt[10] = '{0, 0, 0,      0,           0,   1, 0, 'h400,  0,           'hF, 0,   0, 1, 0, 0, 0,     0,   0,            0, 0,            0, 0,            0, 0};
    vt[11] = '{0, 0, 0,      0,           0,   0, 0, 0,      0,           0,   0,   0, 0, 0, 0, 0,     0,   0,            0, 0,            1, 0,            0, 1};
    vt[12] = '{1, 0, 'h10,   0,           'hF, 0, 0, 0,      0,           0,   0,   0, 0, 1, 0, 4,     'hF, 0,            0, 0,            0, 0,            0, 1};
    vt[13] = '{1, 0, 'h14,   0,           'hF, 0, 0, 0,      0,           0,   1,   1, 0, 0, 0, 0,     0,   0,            1, 'hDEADBEEF,   0, 0,            0, 1};
    vt[14] = '{1, 0, 'h14,   0,           'hF, 0, 0, 0,      0,           0,   1,   1, 0, 0, 0, 0,     0,   0,            0, 0,            0, 0,            0, 1};
    vt[15] = '{1, 0, 'h14,   0,           'hF, 1, 1, 'h40,   'h12345678,  'hF, 1,   1, 1, 1, 1, 'h10,  'hF, 'h12345678,   0, 0,            0, 0,            1, 1};
    vt[16] = '{1, 0, 'h14,   0,           'hF, 1, 0, 'h40,   0,           'hF, 1,   1, 1, 1, 0, 'h10,  'hF, 0,            0, 0,            0, 0,            1, 1};
    vt[17] = '{1, 0, 'h14,   0,           'hF, 0, 0, 0,      0,           0,   0,   1, 0, 0, 0, 0,     0,   0,            0, 0,            1, 'h12345678,   1, 1};
    vt[18] = '{1, 0, 'h10,   0,           'hF, 0, 0, 0,      0,           0,   0,   0, 0, 1, 0, 4,     'hF, 0,            0, 0,            0, 0,            0, 1};
    vt[19] = '{0, 0, 0,      0,           0,   0, 0, 0,      0,           0,   0,   0, 0, 0, 0, 0,     0,   0,            1, 'hDEADBEEF,   0, 0,            0, 1};

    // Reset: CPU requesting must stall, no grant, all registered outputs at reset values.
    rst_n = 1'b0;
    drive(1, 0, 32'h10, 0, 4'hF, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #3;
    chk("rst_cpu_stall", -1, 32'(bus.cpu_stall), 32'd1);
    chk("rst_mem_en",    -1, 32'(bus.mem_en),    32'd0);
    chk("rst_dbg_gnt",   -1, 32'(bus.dbg_gnt),   32'd0);
    chk("rst_cpu_rvalid",-1, 32'(bus.cpu_rvalid),32'd0);
    chk("rst_dbg_rvalid",-1, 32'(bus.dbg_rvalid),32'd0);
    chk("rst_cpu_rdata", -1, bus.cpu_rdata,      32'd0);
    chk("rst_dbg_rdata", -1, bus.dbg_rdata,      32'd0);
    chk("rst_halted",    -1, 32'(bus.dbg_halted),32'd0);
    chk("rst_err",       -1, 32'(bus.err),       32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk); #1;
      drive(vt[i].creq, vt[i].cwe, vt[i].caddr, vt[i].cwdata, vt[i].cbe,
            vt[i].dreq, vt[i].dwe, vt[i].daddr, vt[i].dwdata, vt[i].dbe, vt[i].halt);
      #3;
      chk("cpu_stall", i, 32'(bus.cpu_stall), 32'(vt[i].stall));
      chk("dbg_gnt",   i, 32'(bus.dbg_gnt),   32'(vt[i].dgnt));
      chk("mem_en",    i, 32'(bus.mem_en),    32'(vt[i].en));
      if (vt[i].en) begin
        chk("mem_we",   i, 32'(bus.mem_we),   32'(vt[i].we));
        chk("mem_addr", i, 32'(bus.mem_addr), 32'(vt[i].maddr));
        chk("mem_be",   i, 32'(bus.mem_be),   32'(vt[i].mbe));
        if (vt[i].we) chk("mem_wdata", i, bus.mem_wdata, vt[i].mwd);
      end
      chk("cpu_rvalid", i, 32'(bus.cpu_rvalid), 32'(vt[i].crv));
      chk("cpu_rdata",  i, bus.cpu_rdata,       vt[i].crd);
      chk("dbg_rvalid", i, 32'(bus.dbg_rvalid), 32'(vt[i].drv));
      chk("dbg_rdata",  i, bus.dbg_rdata,       vt[i].drd);
      chk("dbg_halted", i, 32'(bus.dbg_halted), 32'(vt[i].halted));
      chk("err",        i, 32'(bus.err),        32'(vt[i].err));
    end

    // Halt request dropped during DRAIN: straight back to RUN, never halted.
    @(posedge clk); #1;
    drive(1, 0, 32'h10, 0, 4'hF, 0, 0, 0, 0, 0, 1);
    #3 chk("abort_req_stall", 100, 32'(bus.cpu_stall), 32'd1);
    @(posedge clk); #1;
    drive(1, 0, 32'h10, 0, 4'hF, 0, 0, 0, 0, 0, 0);
    #3 chk("abort_drain_stall", 101, 32'(bus.cpu_stall), 32'd1);
    chk("abort_drain_halted", 101, 32'(bus.dbg_halted), 32'd0);
    @(posedge clk); #3;
    chk("abort_run_stall",  102, 32'(bus.cpu_stall),  32'd0);
    chk("abort_run_halted", 102, 32'(bus.dbg_halted), 32'd0);
    chk("abort_run_mem_en", 102, 32'(bus.mem_en),     32'd1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3 chk("abort_rvalid", 103, 32'(bus.cpu_rvalid), 32'd1);
    chk("abort_rdata", 103, bus.cpu_rdata, 32'hDEADBEEF);

    // Reset asserted the cycle after a CPU read grant: the read must never return.
    @(posedge clk); #1;
    drive(1, 0, 32'h14, 0, 4'hF, 0, 0, 0, 0, 0, 0);
    #3 chk("mid_rst_grant", 110, 32'(bus.cpu_stall), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #3;
    chk("mid_rst_cpu_rvalid", 111, 32'(bus.cpu_rvalid), 32'd0);
    chk("mid_rst_cpu_rdata",  111, bus.cpu_rdata,       32'd0);
    chk("mid_rst_stall",      111, 32'(bus.cpu_stall),  32'd1);
    chk("mid_rst_err",        111, 32'(bus.err),        32'd0);
    chk("mid_rst_halted",     111, 32'(bus.dbg_halted), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #3;
    chk("post_rst_cpu_rvalid", 112, 32'(bus.cpu_rvalid), 32'd0);
    chk("post_rst_dbg_rvalid", 112, 32'(bus.dbg_rvalid), 32'd0);
    chk("post_rst_mem_en",     112, 32'(bus.mem_en),     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port of the five-stage pipelined CPU between the MEM-stage load/store unit and a debug/loader port, replacing backdoor preload and dump of data memory with real bus traffic. Performs round-robin arbitration, stalls the pipeline when the CPU loses, routes one-cycle-latency read data back to its owner, and implements a halt handshake so the debug port can own memory exclusively.

## Interface
- DATA_MEM_SIZE, 1024: data memory size in bytes; a multiple of 4.
- ADDR_W, 32: byte-address width on both requester ports.

- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req / cpu_we  in  1 / 1  MEM-stage access request / write enable.
- cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- cpu_wdata / cpu_be  in  32 / 4  write data / byte enables.
- cpu_stall  out  1  pipeline stall: cpu_req & ~cpu_gnt.
- cpu_rdata / cpu_rvalid  out  32 / 1  read return and its one-cycle valid pulse.
- dbg_req / dbg_we / dbg_addr / dbg_wdata / dbg_be  in  1/1/ADDR_W/32/4  debug access, same semantics as the CPU port.
- dbg_gnt  out  1  debug access accepted this cycle.
- dbg_rdata / dbg_rvalid  out  32 / 1  debug read return.
- dbg_halt_req  in  1  request exclusive memory ownership.
- dbg_halted  out  1  CPU locked out; debug owns memory.
- mem_en / mem_we  out  1 / 1  memory port strobe / write.
- mem_addr  out  ADDR_W-2  word index (addr[ADDR_W-1:2]).
- mem_wdata / mem_be  out  32 / 4  write data / byte enables.
- mem_rdata  in  32  synchronous read data, valid the cycle after mem_en & ~mem_we.
- err  out  1  sticky out-of-range flag.

## Operation
- Grants are combinational in the request cycle; at most one grant per cycle; mem_* driven from the winner.
- Round-robin: if both request and the CPU is eligible, the port not granted last time wins. last_owner resets to DBG, so the CPU wins the first contention. A sole requester is always granted when eligible.
- CPU eligible only in state RUN; otherwise cpu_stall = cpu_req.
- Out-of-range: byte address > DATA_MEM_SIZE-4. Such an access is granted (no stall/hang) with mem_en=0; a read returns 0 with a normal rvalid pulse; err sets and holds until reset.
- Read routing: a registered owner tag plus pending bit steer mem_rdata to cpu_rdata or dbg_rdata. The non-owner rdata is 0. Writes produce no rvalid.
- Halt FSM, reset state RUN:
  - RUN -> DRAIN when dbg_halt_req=1; no CPU grant that cycle.
  - DRAIN lasts exactly one cycle so any CPU read granted in the last RUN cycle returns. It then goes to HALTED, or back to RUN if dbg_halt_req has dropped.
  - HALTED: dbg_halted=1; CPU never granted; debug is granted every request.
  - HALTED -> RUN the cycle after dbg_halt_req=0.
- Debug accesses are served in all states.

## Timing
- Reset values: cpu_rvalid=0, dbg_rvalid=0, cpu_rdata=0, dbg_rdata=0, dbg_halted=0, err=0, mem_en=0, state=RUN, last_owner=DBG, pending=0.
- The combinational outputs cpu_stall, dbg_gnt and mem_* follow the inputs during reset with no CPU grant.
- Read latency: request in cycle N; rvalid and rdata for the owner in cycle N+1.
- Back-to-back reads from alternating owners are allowed, one per cycle, with no bubble.
- dbg_halted rises 2 cycles after dbg_halt_req rises (RUN -> DRAIN -> HALTED).
- Reset mid-operation clears any pending read; no rvalid is issued after reset.

## Test plan
- CPU-only read of 0x0000_0010 with memory word 4 = 0xDEADBEEF: mem_addr=4 in cycle N; cpu_rvalid=1 and cpu_rdata=0xDEADBEEF in N+1; cpu_stall=0 throughout.
- Both ports request continuously for 4 cycles after reset: grants go CPU, DBG, CPU, DBG; cpu_stall=1 in cycles 2 and 4 only.
- dbg_halt_req raised while the CPU streams reads: no CPU grant from the request cycle on; the last CPU read still returns in DRAIN; dbg_halted=1 two cycles later. A debug write of 0x12345678 to 0x40 with be=0xF appears on mem_* with mem_addr=0x10.
- Debug read at byte address DATA_MEM_SIZE (1024): mem_en=0, dbg_rvalid=1 next cycle with dbg_rdata=0, err=1 and it stays 1.
- CPU byte store with be=0x2: mem_be=0x2, mem_we=1, no rvalid. rst_n pulsed low the cycle after a CPU read grant: no cpu_rvalid, all outputs at reset values.
